// File: rtl/alu_execute_unit.sv
// alu_execute_unit: execute stage between the A/B operand registers and the O register.
// It handles ADD/SUB/AND/OR/XOR in a single cycle. MUL is an iterative shift-add over
// INPUT_WIDTH cycles. A one-cycle ldo strobe marks each valid result.
module alu_execute_unit #(
    parameter int INPUT_WIDTH  = 4,
    parameter int OUTPUT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [2:0]              opcode,
    input  logic [INPUT_WIDTH-1:0]  a_in,
    input  logic [INPUT_WIDTH-1:0]  b_in,
    output logic [OUTPUT_WIDTH-1:0] result,
    output logic                    ldo,
    output logic                    busy,
    output logic                    carry,
    output logic                    zero,
    output logic                    illegal
);

    localparam int CW = $clog2(INPUT_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MULT     = 2'd1,
        COMPLETE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_MUL = 3'b101
    } op_t;

    state_t                  state_q;
    logic [OUTPUT_WIDTH-1:0] result_q;
    logic                    ldo_q;
    logic                    busy_q;
    logic                    carry_q;
    logic                    zero_q;
    logic                    illegal_q;
    logic [OUTPUT_WIDTH-1:0] acc_q;
    logic [OUTPUT_WIDTH-1:0] mcand_q;
    logic [INPUT_WIDTH-1:0]  mplier_q;
    logic [CW-1:0]           count_q;

    logic [OUTPUT_WIDTH-1:0] a_ext_d;
    logic [OUTPUT_WIDTH-1:0] b_ext_d;
    logic [OUTPUT_WIDTH-1:0] alu_d;
    logic                    alu_carry_d;
    logic [OUTPUT_WIDTH-1:0] acc_d;

    // Single-cycle ALU result and carry/borrow computed from the live operands.
    always_comb begin
        a_ext_d     = OUTPUT_WIDTH'(a_in);
        b_ext_d     = OUTPUT_WIDTH'(b_in);
        alu_d       = '0;
        alu_carry_d = 1'b0;
        case (op_t'(opcode))
            OP_ADD: begin
                alu_d       = a_ext_d + b_ext_d;
                alu_carry_d = alu_d[INPUT_WIDTH];
            end
            OP_SUB: begin
                alu_d       = a_ext_d - b_ext_d;
                alu_carry_d = (a_in < b_in);
            end
            OP_AND:  alu_d = a_ext_d & b_ext_d;
            OP_OR:   alu_d = a_ext_d | b_ext_d;
            OP_XOR:  alu_d = a_ext_d ^ b_ext_d;
            default: alu_d = '0;
        endcase
    end

    // Next partial product for one shift-add multiply step.
    always_comb begin
        acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    // Control FSM with registered result, flags and strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            result_q  <= '0;
            ldo_q     <= 1'b0;
            busy_q    <= 1'b0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
        end else begin
            ldo_q     <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    if (start) begin
                        if (opcode == OP_MUL) begin
                            acc_q    <= '0;
                            mcand_q  <= a_ext_d;
                            mplier_q <= b_in;
                            count_q  <= CW'(INPUT_WIDTH);
                            busy_q   <= 1'b1;
                            state_q  <= MULT;
                        end else if (opcode == 3'b110 || opcode == 3'b111) begin
                            illegal_q <= 1'b1;
                        end else begin
                            result_q <= alu_d;
                            carry_q  <= alu_carry_d;
                            zero_q   <= (alu_d == '0);
                            ldo_q    <= 1'b1;
                            busy_q   <= 1'b1;
                            state_q  <= COMPLETE;
                        end
                    end
                end
                MULT: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q - 1'b1;
                    // The final step writes the product while entering COMPLETE. This keeps
                    // result/ldo registered and visible for exactly the COMPLETE cycle.
                    if (count_q == CW'(1)) begin
                        result_q <= acc_d;
                        carry_q  <= 1'b0;
                        zero_q   <= (acc_d == '0);
                        ldo_q    <= 1'b1;
                        state_q  <= COMPLETE;
                    end
                end
                COMPLETE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign result  = result_q;
    assign ldo     = ldo_q;
    assign busy    = busy_q;
    assign carry   = carry_q;
    assign zero    = zero_q;
    assign illegal = illegal_q;

endmodule
